cycle_frame_buffer: RTL and testbench
=====================================

Name: cycle_frame_buffer

Overview:
- Sits directly downstream of the power-frequency peak sampler.
- Collects the strobed 16-bit samples of one power-frequency cycle into a ping-pong RAM bank, and tracks per-frame max, min, max index and sample count.
- Hands the completed bank to the MCU readout logic with a ready/ack handshake.
- Lets the MCU read a full cycle while the next cycle is being written.

Parameters:
- DATA_W, 16, sample width; samples are unsigned.
- DEPTH, 4096, words per bank; must be at least 3649 (3648 + 1 margin sample per cycle).
- ADDR_W, 12, log2(DEPTH).
- DROP_W, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse on the power-frequency rising edge.
- data_in  in  DATA_W  sample from the peak sampler.
- data_valid  in  1  one-cycle strobe qualifying data_in.
- frame_ack  in  1  pulse from the MCU side releasing the ready bank.
- rd_addr  in  ADDR_W  read address within the ready bank.
- rd_data  out  DATA_W  word at rd_addr of the ready bank; 1-cycle latency.
- frame_ready  out  1  level; a completed bank is available.
- frame_len  out  ADDR_W+1  sample count of the ready frame.
- frame_max  out  DATA_W  maximum sample of the ready frame.
- frame_min  out  DATA_W  minimum sample of the ready frame.
- max_index  out  ADDR_W  index of the first occurrence of frame_max.
- drop_cnt  out  DROP_W  frames discarded because the previous one was not acked; saturates.
- busy  out  1  high while in FILL or FULL.

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.
- All logic is sampled on the rising edge of clk.

Behaviour:
Reset (rst = 1 at a clock edge):
- All outputs are 0.
- State goes to IDLE. wr_bank = 0, rd_bank = 1.
- Accumulators are cleared. A frame being filled is abandoned.

States: IDLE, FILL, FULL.
- IDLE: data_valid is ignored. On frame_start: go to FILL, wr_ptr = 0, acc_max = 0, acc_min = all ones, acc_idx = 0.
- FILL, each data_valid:
  - Write data_in to RAM[{wr_bank, wr_ptr}] and increment wr_ptr.
  - If data_in > acc_max (strictly greater), set acc_max = data_in and acc_idx = wr_ptr.
  - If data_in < acc_min, set acc_min = data_in.
  - When wr_ptr reaches DEPTH after a write, go to FULL; further samples are ignored.
- FULL: data_valid is ignored until frame_start.
- FILL or FULL with frame_start closes the frame (see commit below), then immediately restarts FILL on the other bank with cleared accumulators.
- Simultaneous frame_start and data_valid: the frame is closed first. The coincident sample becomes sample 0 of the new frame and also seeds its max, min and idx.
- A frame closed with wr_ptr = 0 is discarded silently: no commit, no drop_cnt change.

Frame commit, on the cycle the frame closes:
- If frame_ready = 0, or frame_ack arrives in the same cycle:
  - Swap the banks (rd_bank takes the old wr_bank).
  - Latch frame_len = wr_ptr, frame_max, frame_min, max_index.
  - Set frame_ready = 1 on the next cycle.
- Otherwise:
  - Keep the banks and the previous frame outputs unchanged.
  - drop_cnt += 1, saturating at all ones.
  - The new frame overwrites the same write bank.

Handshake:
- frame_ack with frame_ready = 1 clears frame_ready on the next cycle; the frame outputs hold their values.
- frame_ack with frame_ready = 0 is ignored.

Read port:
- rd_data = RAM[{rd_bank, rd_addr}], registered, 1-cycle latency.
- Valid regardless of frame_ready.
- Reads at or beyond frame_len return stale data; this is not an error.

Write/read collision:
- Reads and writes never target the same bank, so no collision handling is needed.

Width rules:
- frame_len is ADDR_W+1 bits so a full bank of DEPTH samples is representable.
- Comparisons are unsigned.

Decomposition:
- Shared package (e.g. signal_pkg):
  - DATA_W and DEPTH constants.
  - State encoding IDLE=2'd0, FILL=2'd1, FULL=2'd2.
- One sub-module, frame_dpram:
  - Simple dual-port RAM, 2*DEPTH x DATA_W.
  - One write port, one registered read port, address MSB = bank.
  - Must be inferable as block RAM.
- Control logic, accumulators and handshake stay in cycle_frame_buffer.

Test Plan:
1. Basic frame:
   - Stimulus: frame_start; 3649 samples data_in = i mod 1000, with 0x1234 at i = 2000; then frame_start.
   - Required: frame_ready = 1 one cycle after the second frame_start; frame_len = 3649, frame_max = 0x1234, max_index = 2000, frame_min = 0.
   - Reading rd_addr 0..3648 returns the written data with 1-cycle latency.
2. Overflow to FULL:
   - Stimulus: 4100 strobes after frame_start.
   - Required: only 4096 are stored; state is FULL; frame_len = 4096 at the next frame_start.
3. Dropped frame:
   - Stimulus: two complete frames with no frame_ack.
   - Required: drop_cnt = 1; frame outputs still describe frame 1.
   - Then ack plus a third frame: frame 3 becomes ready.
   - 300 unacked frames: drop_cnt saturates at 255.
4. Ack coincident with commit:
   - Stimulus: frame_ack on the same cycle frame 2 closes, while frame_ready = 1.
   - Required: frame 2 is committed, drop_cnt is unchanged, frame_ready stays 1.
5. Coincident start and sample:
   - Stimulus: frame_start and data_valid with data 0xFFFF in the same cycle.
   - Required: the sample is index 0 of the new frame; that frame reports max = 0xFFFF, max_index = 0.
6. Reset mid-FILL:
   - Stimulus: rst after 500 samples.
   - Required: all outputs 0; the partial frame is never reported.
   - Next frame_start plus 10 samples, then frame_start: frame_len = 10.

Source files
------------

// File: rtl/cycle_frame_buffer_pkg.sv
// Shared constants and state encoding for the power-frequency cycle frame buffer.
//   DATA_W : sample width (unsigned samples)
//   DEPTH  : words per ping-pong bank (>= 3649 samples of one cycle)
//   ADDR_W : log2(DEPTH), word address within one bank
//   DROP_W : width of the saturating dropped-frame counter
package cycle_frame_buffer_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

endpackage

// File: rtl/cycle_frame_buffer_dpram.sv
// Simple dual-port RAM holding both ping-pong banks (address MSB = bank).
// Ports:
//   clk, rst          : clock and synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_addr/rd_data   : registered read port, 1-cycle latency
module cycle_frame_buffer_dpram #(
    parameter int DATA_W = 16,
    parameter int AW     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register reset maps onto the block RAM's output-latch reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cycle_frame_buffer.sv
// Collects one power-frequency cycle of strobed samples into a ping-pong bank,
// tracks max/min/max index/count, and hands the finished bank to the MCU side
// with a ready/ack handshake while the next cycle is written to the other bank.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   frame_start   : pulse at each power-frequency rising edge
//   data_in/data_valid : sample stream from the peak sampler
//   frame_ack     : MCU releases the ready bank
//   rd_addr/rd_data : read port into the ready bank (1-cycle latency)
//   frame_ready, frame_len, frame_max, frame_min, max_index : ready-frame info
//   drop_cnt      : saturating count of frames lost to a missing ack
//   busy          : collecting (FILL or FULL)
module cycle_frame_buffer
    import cycle_frame_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_len,
    output logic [DATA_W-1:0] frame_max,
    output logic [DATA_W-1:0] frame_min,
    output logic [ADDR_W-1:0] max_index,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    state_t state_reg, state_next;

    // rd_bank is always the complement of wr_bank, so one bit holds both.
    logic              wr_bank_reg;
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [DATA_W-1:0] acc_max_reg;
    logic [DATA_W-1:0] acc_min_reg;
    logic [ADDR_W-1:0] acc_idx_reg;
    logic              frame_ready_reg;
    logic [ADDR_W:0]   frame_len_reg;
    logic [DATA_W-1:0] frame_max_reg;
    logic [DATA_W-1:0] frame_min_reg;
    logic [ADDR_W-1:0] max_index_reg;
    logic [DROP_W-1:0] drop_cnt_reg;

    logic              closing;
    logic              commit;
    logic              drop;
    logic              take_sample;
    logic              wr_bank_eff;
    logic [ADDR_W-1:0] wr_addr_low;

    // A close with no samples is silently discarded.
    assign closing     = frame_start && (state_reg != IDLE) && (wr_ptr_reg != '0);
    assign commit      = closing && (!frame_ready_reg || frame_ack);
    assign drop        = closing && !commit;
    // A sample coincident with frame_start belongs to the new frame.
    assign take_sample = data_valid && (frame_start || (state_reg == FILL));
    assign wr_bank_eff = commit ? ~wr_bank_reg : wr_bank_reg;
    assign wr_addr_low = frame_start ? '0 : wr_ptr_reg[ADDR_W-1:0];

    cycle_frame_buffer_dpram #(
        .DATA_W (DATA_W),
        .AW     (ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (take_sample),
        .wr_addr ({wr_bank_eff, wr_addr_low}),
        .wr_data (data_in),
        .rd_addr ({~wr_bank_reg, rd_addr}),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (frame_start) begin
            state_next = FILL;
        end else if (state_reg == FILL && data_valid && wr_ptr_reg == LAST_PTR) begin
            state_next = FULL;
        end
    end

    // Output logic
    always_comb begin
        busy = (state_reg == FILL) || (state_reg == FULL);
    end

    // Datapath: write pointer, accumulators, commit and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_reg     <= 1'b0;
            wr_ptr_reg      <= '0;
            acc_max_reg     <= '0;
            acc_min_reg     <= '0;
            acc_idx_reg     <= '0;
            frame_ready_reg <= 1'b0;
            frame_len_reg   <= '0;
            frame_max_reg   <= '0;
            frame_min_reg   <= '0;
            max_index_reg   <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            if (frame_start) begin
                wr_ptr_reg  <= take_sample ? (ADDR_W+1)'(1) : '0;
                acc_max_reg <= take_sample ? data_in : '0;
                acc_min_reg <= take_sample ? data_in : '1;
                acc_idx_reg <= '0;
            end else if (take_sample) begin
                wr_ptr_reg <= wr_ptr_reg + (ADDR_W+1)'(1);
                if (data_in > acc_max_reg) begin
                    acc_max_reg <= data_in;
                    acc_idx_reg <= wr_ptr_reg[ADDR_W-1:0];
                end
                if (data_in < acc_min_reg) begin
                    acc_min_reg <= data_in;
                end
            end

            if (commit) begin
                wr_bank_reg     <= ~wr_bank_reg;
                frame_len_reg   <= wr_ptr_reg;
                frame_max_reg   <= acc_max_reg;
                frame_min_reg   <= acc_min_reg;
                max_index_reg   <= acc_idx_reg;
                frame_ready_reg <= 1'b1;
            end else if (frame_ack) begin
                frame_ready_reg <= 1'b0;
            end

            if (drop && drop_cnt_reg != '1) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
            end
        end
    end

    assign frame_ready = frame_ready_reg;
    assign frame_len   = frame_len_reg;
    assign frame_max   = frame_max_reg;
    assign frame_min   = frame_min_reg;
    assign max_index   = max_index_reg;
    assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_cycle_frame_buffer.sv
module tb_cycle_frame_buffer;
    import cycle_frame_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic              frame_ack = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              frame_ready;
    logic [ADDR_W:0]   frame_len;
    logic [DATA_W-1:0] frame_max;
    logic [DATA_W-1:0] frame_min;
    logic [ADDR_W-1:0] max_index;
    logic [DROP_W-1:0] drop_cnt;
    logic              busy;

    int tests = 0;
    int fails = 0;

    cycle_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_len   (frame_len),
        .frame_max   (frame_max),
        .frame_min   (frame_min),
        .max_index   (max_index),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic sample(input logic [DATA_W-1:0] v);
        data_valid = 1'b1;
        data_in    = v;
        step();
        data_valid = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    task automatic read_chk(input int a, input logic [31:0] exp);
        rd_addr = ADDR_W'(a);
        step();
        chk($sformatf("rd_data[%0d]", a), 32'(rd_data), exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_data"},     32'(rd_data),     0);
        chk({tag, " frame_ready"}, 32'(frame_ready), 0);
        chk({tag, " frame_len"},   32'(frame_len),   0);
        chk({tag, " frame_max"},   32'(frame_max),   0);
        chk({tag, " frame_min"},   32'(frame_min),   0);
        chk({tag, " max_index"},   32'(max_index),   0);
        chk({tag, " drop_cnt"},    32'(drop_cnt),    0);
        chk({tag, " busy"},        32'(busy),        0);
    endtask

    task automatic chk_frame(input string tag, input int len, input int mx, input int mn, input int idx);
        chk({tag, " frame_len"}, 32'(frame_len), len);
        chk({tag, " frame_max"}, 32'(frame_max), mx);
        chk({tag, " frame_min"}, 32'(frame_min), mn);
        chk({tag, " max_index"}, 32'(max_index), idx);
    endtask

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        chk_all_zero("reset");

        // 1. Basic frame: 3649 samples of i mod 1000, 0x1234 at i = 2000
        pulse_start();
        chk("t1 busy", 32'(busy), 1);
        for (int i = 0; i < 3649; i++) begin
            sample((i == 2000) ? 16'h1234 : 16'(i % 1000));
        end
        chk("t1 ready before close", 32'(frame_ready), 0);
        pulse_start();
        chk("t1 frame_ready", 32'(frame_ready), 1);
        chk_frame("t1", 3649, 32'h1234, 0, 2000);
        for (int a = 0; a < 3649; a++) begin
            read_chk(a, (a == 2000) ? 32'h1234 : 32'(a % 1000));
        end

        // Handshake: ack clears ready, frame outputs hold
        ack();
        chk("ack frame_ready", 32'(frame_ready), 0);
        chk("ack frame_len hold", 32'(frame_len), 3649);

        // 2. Overflow: 4100 strobes, values 3*i+5; only the first 4096 count
        for (int i = 0; i < 4100; i++) begin
            sample(16'(3 * i + 5));
        end
        chk("t2 busy in FULL", 32'(busy), 1);
        pulse_start();
        chk("t2 frame_ready", 32'(frame_ready), 1);
        chk_frame("t2", 4096, 3 * 4095 + 5, 5, 4095);
        read_chk(0, 5);
        read_chk(4095, 3 * 4095 + 5);

        // 3. Dropped frame: ready still set, no ack
        sample(16'd10);
        sample(16'd20);
        sample(16'd30);
        pulse_start();
        chk("t3 drop_cnt", 32'(drop_cnt), 1);
        chk("t3 ready kept", 32'(frame_ready), 1);
        chk_frame("t3 still frame2", 4096, 3 * 4095 + 5, 5, 4095);
        ack();
        chk("t3 ack ready", 32'(frame_ready), 0);
        sample(16'd7);
        sample(16'd3);
        sample(16'd9);
        sample(16'd9);
        sample(16'd1);
        pulse_start();
        chk("t3 next ready", 32'(frame_ready), 1);
        chk_frame("t3 next", 5, 9, 1, 2);
        chk("t3 drop_cnt hold", 32'(drop_cnt), 1);
        read_chk(0, 7);
        read_chk(1, 3);
        read_chk(4, 1);

        // 4. Ack coincident with commit while ready = 1
        sample(16'd100);
        sample(16'd200);
        sample(16'd150);
        frame_start = 1'b1;
        frame_ack   = 1'b1;
        step();
        frame_start = 1'b0;
        frame_ack   = 1'b0;
        chk("t4 frame_ready", 32'(frame_ready), 1);
        chk_frame("t4", 3, 200, 100, 1);
        chk("t4 drop_cnt", 32'(drop_cnt), 1);

        // 5. Coincident start and sample 0xFFFF
        sample(16'd5);
        sample(16'd6);
        frame_start = 1'b1;
        frame_ack   = 1'b1;
        data_valid  = 1'b1;
        data_in     = 16'hFFFF;
        step();
        frame_start = 1'b0;
        frame_ack   = 1'b0;
        data_valid  = 1'b0;
        chk_frame("t5 closed", 2, 6, 5, 1);
        sample(16'h0010);
        sample(16'hFFFF);
        frame_start = 1'b1;
        frame_ack   = 1'b1;
        step();
        frame_start = 1'b0;
        frame_ack   = 1'b0;
        chk_frame("t5 seeded", 3, 32'hFFFF, 32'h0010, 0);
        read_chk(0, 32'hFFFF);
        read_chk(1, 32'h0010);
        read_chk(2, 32'hFFFF);

        // 3b. 300 unacked frames: drop_cnt saturates
        for (int f = 0; f < 300; f++) begin
            sample(16'd1);
            pulse_start();
        end
        chk("t3b drop_cnt sat", 32'(drop_cnt), 255);
        chk("t3b frame_len hold", 32'(frame_len), 3);

        // 6. Reset mid-FILL
        for (int i = 0; i < 500; i++) begin
            sample(16'(i + 1));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("t6 reset");
        step();
        chk("t6 partial not reported", 32'(frame_ready), 0);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            sample(16'(i + 1));
        end
        pulse_start();
        chk("t6 frame_ready", 32'(frame_ready), 1);
        chk_frame("t6", 10, 10, 1, 9);
        chk("t6 drop_cnt", 32'(drop_cnt), 0);

        // Empty frame closed: discarded silently
        ack();
        pulse_start();
        chk("empty ready", 32'(frame_ready), 0);
        chk("empty drop_cnt", 32'(drop_cnt), 0);
        chk("empty frame_len hold", 32'(frame_len), 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
